// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: sequences a multi-cycle multiply into HI/LO; ports: clock/clear, start/op_a/op_b in, mul_a/mul_b/product to/from multiplier, busy/done, bus_in/hi_wr/lo_wr, hi_out/lo_out
module mul_hilo_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic [WIDTH-1:0]   op_a,
  input  logic [WIDTH-1:0]   op_b,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done,
  input  logic [WIDTH-1:0]   bus_in,
  input  logic               hi_wr,
  input  logic               lo_wr,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, hi_q, hi_d, lo_q, lo_d;
  logic accept, capture, wr_ok;
  always_comb begin
    accept  = start && state_q != SETTLE;
    capture = state_q == SETTLE && cnt_q == 4'd0;
    wr_ok   = !accept && state_q != SETTLE;
    state_d = accept ? SETTLE : state_q == SETTLE ? (capture ? DONE : SETTLE) : IDLE;
    cnt_d   = accept ? 4'(SETTLE_CYCLES - 1) : (state_q == SETTLE && !capture) ? cnt_q - 4'd1 : cnt_q;
    mul_a_d = accept ? op_a : mul_a_q;
    mul_b_d = accept ? op_b : mul_b_q;
    hi_d    = capture ? product[2*WIDTH-1:WIDTH] : (wr_ok && hi_wr) ? bus_in : hi_q;
    lo_d    = capture ? product[WIDTH-1:0] : (wr_ok && lo_wr) ? bus_in : lo_q;
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign mul_a  = mul_a_q;
  assign mul_b  = mul_b_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
  assign busy   = state_q == SETTLE;
  assign done   = state_q == DONE;
endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// tb_mul_hilo_ctrl: directed scoreboard bench for mul_hilo_ctrl with a behavioural multiplier
module tb_mul_hilo_ctrl;
  logic clock = 0, clear = 1, start = 0, hi_wr = 0, lo_wr = 0;
  logic [31:0] op_a = 0, op_b = 0, bus_in = 0, mul_a, mul_b, hi_out, lo_out;
  logic [63:0] product;
  logic busy, done;
  logic [63:0] sb[$];
  int n_cmp = 0, n_err = 0;

  mul_hilo_ctrl #(.SETTLE_CYCLES(2), .WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .op_a(op_a), .op_b(op_b),
    .mul_a(mul_a), .mul_b(mul_b), .product(product), .busy(busy), .done(done),
    .bus_in(bus_in), .hi_wr(hi_wr), .lo_wr(lo_wr), .hi_out(hi_out), .lo_out(lo_out)
  );

  always #5 clock = ~clock;
  always_comb product = 64'(longint'($signed(mul_a)) * longint'($signed(mul_b)));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic go(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    op_a = a; op_b = b; start = 1;
    sb.push_back(exp);
  endtask

  task automatic check_done(input string tag);
    logic [63:0] e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_done"}, done, 1);
      chk({tag, "_hilo"}, {hi_out, lo_out}, e);
    end
  endtask

  task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int cyc = 0;
    go(a, b, exp);
    step(); cyc++;
    start = 0;
    while (!done && cyc < 20) begin
      step(); cyc++;
    end
    chk({tag, "_latency"}, cyc, 3);
    check_done(tag);
  endtask

  initial begin
    step(); step();
    chk("reset_outs", {hi_out, lo_out, mul_a, mul_b}, 0);
    chk("reset_flags", {busy, done}, 0);
    clear = 0;
    step();
    go(32'd7, -32'sd3, 64'hFFFFFFFF_FFFFFFEB);
    step(); start = 0;
    chk("b1_c1", {busy, done}, 2'b10);
    chk("b1_mul", {mul_a, mul_b}, {32'd7, -32'sd3});
    step();
    chk("b1_c2", {busy, done}, 2'b10);
    step();
    check_done("b1");
    step();
    chk("b1_c4", {busy, done}, 2'b00);
    chk("b1_hold_mul", {mul_a, mul_b}, {32'd7, -32'sd3});
    chk("b1_hold_hilo", {hi_out, lo_out}, 64'hFFFFFFFF_FFFFFFEB);
    run("minmin", 32'h80000000, 32'h80000000, 64'h40000000_00000000);
    step();
    run("m1m1", 32'hFFFFFFFF, 32'hFFFFFFFF, 64'h00000000_00000001);
    step();
    go(32'd5, 32'd6, 64'd30);
    step();
    op_a = 9; op_b = 9;
    step(); start = 0;
    chk("ign_mul", {mul_a, mul_b}, {32'd5, 32'd6});
    step();
    check_done("ign");
    for (int i = 0; i < 4; i++) begin
      step();
      chk("ign_no_extra_done", {busy, done}, 0);
    end
    go(32'd5, 32'd6, 64'd30);
    step(); step(); step();
    check_done("b2b_first");
    sb.push_back(64'd6);
    op_a = 2; op_b = 3;
    step(); start = 0;
    chk("b2b_busy", busy, 1);
    chk("b2b_mul", {mul_a, mul_b}, {32'd2, 32'd3});
    step(); step();
    check_done("b2b_second");
    step();
    go(32'd7, -32'sd3, 64'hFFFFFFFF_FFFFFFEB);
    void'(sb.pop_back());
    step(); start = 0;
    clear = 1;
    step(); clear = 0;
    chk("abort_state", {busy, done}, 0);
    chk("abort_regs", {hi_out, lo_out, mul_a, mul_b}, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("abort_no_done", done, 0);
    end
    bus_in = 32'h12345678; hi_wr = 1;
    step(); hi_wr = 0;
    chk("hi_wr", {hi_out, lo_out}, {32'h12345678, 32'h0});
    bus_in = 32'hCAFEBABE; hi_wr = 1; lo_wr = 1;
    step(); hi_wr = 0; lo_wr = 0;
    chk("both_wr", {hi_out, lo_out}, {2{32'hCAFEBABE}});
    go(32'd5, 32'd6, 64'd30);
    bus_in = 32'h55555555; hi_wr = 1;
    step(); start = 0; hi_wr = 0;
    chk("start_drops_wr", hi_out, 32'hCAFEBABE);
    bus_in = 32'hAAAAAAAA; lo_wr = 1;
    step(); lo_wr = 0;
    chk("settle_drops_wr", lo_out, 32'hCAFEBABE);
    step();
    check_done("after_wr");
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
